// File: rtl/id_decode.sv
// ----------------------------------------------------------------------------
// id_decode
//
// Instruction-decode stage of the five-stage integer pipeline. It decodes the
// 32-bit instruction from fetch, reads the register file, and resolves both
// source operands through forwarding from the EX, MEM and WB write-back
// buses. The result is registered into the alusel/aluop/operand/destination
// bundle that EX consumes.
//
// Two hazards cannot be covered by forwarding, and both stall fetch for one
// cycle while a bubble is loaded into the output register:
//   - RAW on the result currently sitting in the output register. That value
//     only reaches the EX write-back bus on the next cycle.
//   - mfhi/mflo directly behind mthi/mtlo. This guarantees one slot of
//     separation so EX sees the new HI/LO value through MEM forwarding.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   inst_valid, if_inst     instruction from fetch (held while stall_req=1)
//   rf_raddr1/2             combinational register-file read addresses (rs, rt)
//   rf_rdata1/2             register-file read data, same cycle
//   ex_*/mem_*/wb_*         write-back buses used for operand forwarding
//   stall_req               combinational; fetch holds PC and if_inst
//   alusel, aluop           registered ALU class and operation
//   reg1_data, reg2_data    registered resolved operands
//   id_we, id_waddr         registered destination write enable / address
// ----------------------------------------------------------------------------
module id_decode (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inst_valid,
    input  logic [31:0] if_inst,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        stall_req,
    output logic [2:0]  alusel,
    output logic [7:0]  aluop,
    output logic [31:0] reg1_data,
    output logic [31:0] reg2_data,
    output logic        id_we,
    output logic [4:0]  id_waddr
);

    // ALU class selectors
    localparam logic [2:0] ALUSEL_NONE  = 3'b000;
    localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [2:0] ALUSEL_MOVE  = 3'b011;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    // SPECIAL function codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_MOVZ = 6'h0A;
    localparam logic [5:0] F_MOVN = 6'h0B;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;

    // Instruction fields
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = if_inst[31:26];
    assign rs    = if_inst[25:21];
    assign rt    = if_inst[20:16];
    assign rd    = if_inst[15:11];
    assign shamt = if_inst[10:6];
    assign funct = if_inst[5:0];
    assign imm   = if_inst[15:0];

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    // Resolved source values
    logic [31:0] src1_val;
    logic [31:0] src2_val;

    // Decoded bundle and hazard qualifiers
    logic [2:0]  dec_alusel;
    logic [7:0]  dec_aluop;
    logic [31:0] dec_reg1;
    logic [31:0] dec_reg2;
    logic        dec_we;
    logic [4:0]  dec_waddr;
    logic        use_rs;
    logic        use_rt;
    logic        is_mfhilo;
    logic        is_mthilo;

    // Set while the output register holds mthi/mtlo
    logic        hilo_pend;

    logic        raw_hazard;
    logic        hilo_hazard;

    // Operand forwarding: the youngest producer wins; $0 is always zero.
    always_comb begin
        src1_val = rf_rdata1;
        if (rs == '0)
            src1_val = '0;
        else if (ex_we && (ex_waddr == rs))
            src1_val = ex_wdata;
        else if (mem_we && (mem_waddr == rs))
            src1_val = mem_wdata;
        else if (wb_we && (wb_waddr == rs))
            src1_val = wb_wdata;
    end

    always_comb begin
        src2_val = rf_rdata2;
        if (rt == '0)
            src2_val = '0;
        else if (ex_we && (ex_waddr == rt))
            src2_val = ex_wdata;
        else if (mem_we && (mem_waddr == rt))
            src2_val = mem_wdata;
        else if (wb_we && (wb_waddr == rt))
            src2_val = wb_wdata;
    end

    // Decode. Anything unrecognised, or an invalid slot, leaves the bubble
    // defaults in place.
    always_comb begin
        dec_alusel = ALUSEL_NONE;
        dec_aluop  = '0;
        dec_reg1   = '0;
        dec_reg2   = '0;
        dec_we     = 1'b0;
        dec_waddr  = '0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        is_mfhilo  = 1'b0;
        is_mthilo  = 1'b0;

        if (inst_valid) begin
            case (op)
                OP_SPECIAL: begin
                    case (funct)
                        F_AND, F_OR, F_XOR, F_NOR: begin
                            dec_alusel = ALUSEL_LOGIC;
                            dec_aluop  = {2'b00, funct};
                            dec_reg1   = src1_val;
                            dec_reg2   = src2_val;
                            dec_we     = 1'b1;
                            dec_waddr  = rd;
                            use_rs     = 1'b1;
                            use_rt     = 1'b1;
                        end
                        F_SLL, F_SRL, F_SRA: begin
                            dec_alusel = ALUSEL_SHIFT;
                            dec_aluop  = {2'b00, funct};
                            dec_reg1   = {27'd0, shamt};
                            dec_reg2   = src2_val;
                            dec_we     = 1'b1;
                            dec_waddr  = rd;
                            use_rt     = 1'b1;
                        end
                        F_SLLV, F_SRLV, F_SRAV: begin
                            dec_alusel = ALUSEL_SHIFT;
                            dec_aluop  = {2'b00, funct};
                            dec_reg1   = src1_val;
                            dec_reg2   = src2_val;
                            dec_we     = 1'b1;
                            dec_waddr  = rd;
                            use_rs     = 1'b1;
                            use_rt     = 1'b1;
                        end
                        F_MOVZ, F_MOVN: begin
                            // Conditional move: the write enable depends on
                            // the resolved rt, so forwarding feeds it too.
                            dec_alusel = ALUSEL_MOVE;
                            dec_aluop  = {2'b00, funct};
                            dec_reg1   = src1_val;
                            dec_reg2   = src2_val;
                            dec_we     = (funct == F_MOVZ) ? (src2_val == '0)
                                                           : (src2_val != '0);
                            dec_waddr  = rd;
                            use_rs     = 1'b1;
                            use_rt     = 1'b1;
                        end
                        F_MFHI, F_MFLO: begin
                            dec_alusel = ALUSEL_MOVE;
                            dec_aluop  = {2'b00, funct};
                            dec_we     = 1'b1;
                            dec_waddr  = rd;
                            is_mfhilo  = 1'b1;
                        end
                        F_MTHI, F_MTLO: begin
                            dec_alusel = ALUSEL_MOVE;
                            dec_aluop  = {2'b00, funct};
                            dec_reg1   = src1_val;
                            use_rs     = 1'b1;
                            is_mthilo  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    dec_alusel = ALUSEL_LOGIC;
                    dec_aluop  = {2'b00, op};
                    dec_reg1   = src1_val;
                    dec_reg2   = {16'd0, imm};
                    dec_we     = 1'b1;
                    dec_waddr  = rt;
                    use_rs     = 1'b1;
                end
                default: ;
            endcase

            // Writes to $0 are discarded; the all-zero NOP never writes.
            if (dec_waddr == '0)
                dec_we = 1'b0;
        end
    end

    // id_we=1 implies id_waddr!=0, so a $0 source can never match here.
    assign raw_hazard  = id_we && ((use_rs && (rs == id_waddr)) ||
                                   (use_rt && (rt == id_waddr)));
    assign hilo_hazard = is_mfhilo && hilo_pend;
    assign stall_req   = inst_valid && (raw_hazard || hilo_hazard);

    // Output register. A stall loads a bubble, which also clears hilo_pend,
    // so the held instruction re-decodes without a hazard on the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alusel    <= ALUSEL_NONE;
            aluop     <= '0;
            reg1_data <= '0;
            reg2_data <= '0;
            id_we     <= 1'b0;
            id_waddr  <= '0;
            hilo_pend <= 1'b0;
        end else if (stall_req) begin
            alusel    <= ALUSEL_NONE;
            aluop     <= '0;
            reg1_data <= '0;
            reg2_data <= '0;
            id_we     <= 1'b0;
            id_waddr  <= '0;
            hilo_pend <= 1'b0;
        end else begin
            alusel    <= dec_alusel;
            aluop     <= dec_aluop;
            reg1_data <= dec_reg1;
            reg2_data <= dec_reg2;
            id_we     <= dec_we;
            id_waddr  <= dec_waddr;
            hilo_pend <= is_mthilo;
        end
    end

endmodule

// File: tb/tb_id_decode.sv
// ----------------------------------------------------------------------------
// tb_id_decode
//
// Self-checking bench for id_decode: directed scenarios for the forwarding,
// stall and HI/LO cases, then randomized instruction streams checked against
// a behavioural model of the decode rules.
// ----------------------------------------------------------------------------
module tb_id_decode;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        inst_valid;
    logic [31:0] if_inst;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_we, mem_we, wb_we;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;
    logic        stall_req;
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic [31:0] reg1_data, reg2_data;
    logic        id_we;
    logic [4:0]  id_waddr;

    always #5 clk = ~clk;

    id_decode dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .inst_valid(inst_valid),
        .if_inst   (if_inst),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .ex_we     (ex_we),
        .ex_waddr  (ex_waddr),
        .ex_wdata  (ex_wdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .stall_req (stall_req),
        .alusel    (alusel),
        .aluop     (aluop),
        .reg1_data (reg1_data),
        .reg2_data (reg2_data),
        .id_we     (id_we),
        .id_waddr  (id_waddr)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected decode result for one instruction
    typedef struct packed {
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        we;
        logic [4:0]  wa;
        logic        use_s;
        logic        use_t;
        logic        mf;
        logic        mt;
    } dec_t;

    // Model of what the output register currently holds
    logic       m_we;
    logic [4:0] m_waddr;
    logic       m_hilo;
    logic       m_stall;

    // Observed values from the last cycle, for directed spot checks
    logic        o_stall;
    logic [2:0]  o_sel;
    logic [7:0]  o_op;
    logic [31:0] o_r1, o_r2;
    logic        o_we;
    logic [4:0]  o_wa;

    // Value a source register reads as: first matching producer in age order.
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rfv);
        logic        we_l [3];
        logic [4:0]  wa_l [3];
        logic [31:0] d_l  [3];
        we_l = '{ex_we, mem_we, wb_we};
        wa_l = '{ex_waddr, mem_waddr, wb_waddr};
        d_l  = '{ex_wdata, mem_wdata, wb_wdata};
        if (r == 5'd0) return 32'd0;
        for (int i = 0; i < 3; i++)
            if (we_l[i] && wa_l[i] == r) return d_l[i];
        return rfv;
    endfunction

    function automatic dec_t model(input logic [31:0] inst, input logic valid);
        dec_t        d;
        logic [5:0]  opc, fn;
        logic [4:0]  s, t, rd;
        logic [31:0] a, b;
        opc = inst[31:26]; fn = inst[5:0];
        s = inst[25:21]; t = inst[20:16]; rd = inst[15:11];
        a = fwd(s, rf_rdata1);
        b = fwd(t, rf_rdata2);
        d = '0;
        if (!valid) return d;
        if (opc == 6'h00) begin
            if (fn inside {[6'h24:6'h27]}) begin
                d.sel = 3'd1; d.r1 = a; d.r2 = b; d.wa = rd; d.we = 1'b1;
                d.use_s = 1'b1; d.use_t = 1'b1;
            end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
                d.sel = 3'd2; d.r1 = 32'(inst[10:6]); d.r2 = b; d.wa = rd; d.we = 1'b1;
                d.use_t = 1'b1;
            end else if (fn inside {6'h04, 6'h06, 6'h07}) begin
                d.sel = 3'd2; d.r1 = a; d.r2 = b; d.wa = rd; d.we = 1'b1;
                d.use_s = 1'b1; d.use_t = 1'b1;
            end else if (fn inside {6'h0A, 6'h0B}) begin
                d.sel = 3'd3; d.r1 = a; d.r2 = b; d.wa = rd;
                d.we = (fn == 6'h0A) ? (b == 0) : (b != 0);
                d.use_s = 1'b1; d.use_t = 1'b1;
            end else if (fn inside {6'h10, 6'h12}) begin
                d.sel = 3'd3; d.wa = rd; d.we = 1'b1; d.mf = 1'b1;
            end else if (fn inside {6'h11, 6'h13}) begin
                d.sel = 3'd3; d.r1 = a; d.use_s = 1'b1; d.mt = 1'b1;
            end
            if (d.sel != 3'd0) d.op = {2'b00, fn};
        end else if (opc inside {[6'h0C:6'h0F]}) begin
            d.sel = 3'd1; d.op = {2'b00, opc}; d.r1 = a; d.r2 = 32'(inst[15:0]);
            d.wa = t; d.we = 1'b1; d.use_s = 1'b1;
        end
        if (d.wa == 5'd0) d.we = 1'b0;
        return d;
    endfunction

    task automatic model_reset();
        m_we = 1'b0; m_waddr = '0; m_hilo = 1'b0; m_stall = 1'b0;
    endtask

    // One decode cycle with the inputs already driven.
    task automatic run_cycle();
        dec_t e;
        logic exp_stall;
        @(negedge clk);
        e = model(if_inst, inst_valid);
        exp_stall = inst_valid &&
                    ((m_we && ((e.use_s && if_inst[25:21] == m_waddr) ||
                               (e.use_t && if_inst[20:16] == m_waddr))) ||
                     (e.mf && m_hilo));
        check("stall_req", 32'(stall_req), 32'(exp_stall));
        check("rf_raddr1", 32'(rf_raddr1), 32'(if_inst[25:21]));
        check("rf_raddr2", 32'(rf_raddr2), 32'(if_inst[20:16]));
        o_stall = stall_req;
        @(posedge clk);
        #1;
        if (exp_stall) e = '0;
        check("alusel",    32'(alusel),   32'(e.sel));
        check("aluop",     32'(aluop),    32'(e.op));
        check("reg1_data", reg1_data,     e.r1);
        check("reg2_data", reg2_data,     e.r2);
        check("id_we",     32'(id_we),    32'(e.we));
        check("id_waddr",  32'(id_waddr), 32'(e.wa));
        o_sel = alusel; o_op = aluop; o_r1 = reg1_data; o_r2 = reg2_data;
        o_we = id_we; o_wa = id_waddr;
        m_we = e.we; m_waddr = e.wa; m_hilo = e.mt; m_stall = exp_stall;
    endtask

    task automatic clear_fwd();
        ex_we = 0; ex_waddr = '0; ex_wdata = '0;
        mem_we = 0; mem_waddr = '0; mem_wdata = '0;
        wb_we = 0; wb_waddr = '0; wb_wdata = '0;
        rf_rdata1 = '0; rf_rdata2 = '0;
    endtask

    task automatic issue(input logic [31:0] inst);
        inst_valid = 1'b1; if_inst = inst;
        run_cycle();
    endtask

    function automatic logic [31:0] rand_inst();
        int unsigned k;
        logic [5:0]  fn;
        logic [4:0]  s, t, rd;
        k  = $urandom_range(0, 19);
        s  = 5'($urandom_range(0, 3));
        t  = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        case (k)
            0: fn = 6'h24;  1: fn = 6'h25;  2: fn = 6'h26;  3: fn = 6'h27;
            4: fn = 6'h00;  5: fn = 6'h02;  6: fn = 6'h03;  7: fn = 6'h04;
            8: fn = 6'h06;  9: fn = 6'h07; 10: fn = 6'h0A; 11: fn = 6'h0B;
           12: fn = 6'h10; 13: fn = 6'h11; 14: fn = 6'h12; 15: fn = 6'h13;
            default: fn = 6'($urandom);
        endcase
        if (k < 16) return {6'h00, s, t, rd, 5'($urandom), fn};
        if (k < 18) return {6'(6'h0C + $urandom_range(0, 3)), s, t, 16'($urandom)};
        if (k == 18) return $urandom;
        return 32'd0;
    endfunction

    function automatic logic [31:0] rand_data();
        return ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    endfunction

    initial begin
        reset_n = 1'b0; inst_valid = 1'b0; if_inst = '0;
        clear_fwd();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_alusel", 32'(alusel), 0);
        check("rst_aluop",  32'(aluop), 0);
        check("rst_reg1",   reg1_data, 0);
        check("rst_reg2",   reg2_data, 0);
        check("rst_we",     32'(id_we), 0);
        check("rst_waddr",  32'(id_waddr), 0);
        check("rst_stall",  32'(stall_req), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ori $1,$0,0x1234
        issue(32'h3401_1234);
        check("ori_sel", 32'(o_sel), 1);
        check("ori_op",  32'(o_op), 32'h0D);
        check("ori_r2",  o_r2, 32'h0000_1234);
        check("ori_wa",  32'(o_wa), 1);

        // ori $1,$0,5 ; or $2,$1,$1 -> one stall, then EX forwarding beats MEM
        issue(32'h3401_0005);
        issue(32'h0021_1025);
        check("raw_stall",  32'(o_stall), 1);
        check("raw_bubble", 32'(o_sel), 0);
        ex_we = 1; ex_waddr = 5'd1; ex_wdata = 32'd5;
        mem_we = 1; mem_waddr = 5'd1; mem_wdata = 32'h99;
        issue(32'h0021_1025);
        check("raw_nostall", 32'(o_stall), 0);
        check("raw_r1",  o_r1, 5);
        check("raw_r2",  o_r2, 5);
        check("raw_op",  32'(o_op), 32'h25);
        clear_fwd();

        // Bubble slot, then sll $3,$2,4 with MEM beating WB on $2
        inst_valid = 1'b0; if_inst = '0; run_cycle();
        mem_we = 1; mem_waddr = 5'd2; mem_wdata = 32'h0F;
        wb_we = 1; wb_waddr = 5'd2; wb_wdata = 32'hAA;
        issue(32'h0002_1900);
        check("sll_sel", 32'(o_sel), 2);
        check("sll_r1",  o_r1, 4);
        check("sll_r2",  o_r2, 32'h0F);
        check("sll_wa",  32'(o_wa), 3);
        clear_fwd();

        // movz/movn $4,$5,$6 with $6 = 0 and $6 = 7
        rf_rdata2 = 32'd0; issue(32'h00A6_200A); check("movz0_we", 32'(o_we), 1);
        rf_rdata2 = 32'd7; issue(32'h00A6_200A); check("movz7_we", 32'(o_we), 0);
        rf_rdata2 = 32'd0; issue(32'h00A6_200B); check("movn0_we", 32'(o_we), 0);
        rf_rdata2 = 32'd7; issue(32'h00A6_200B); check("movn7_we", 32'(o_we), 1);
        clear_fwd();

        // mthi $7 ; mfhi $8 -> one stall, then the move
        issue(32'h00E0_0011);
        issue(32'h0000_4010);
        check("hilo_stall", 32'(o_stall), 1);
        issue(32'h0000_4010);
        check("mfhi_sel", 32'(o_sel), 3);
        check("mfhi_op",  32'(o_op), 32'h10);
        check("mfhi_we",  32'(o_we), 1);
        check("mfhi_wa",  32'(o_wa), 8);
        // mthi ; independent ori ; mfhi -> no stall
        issue(32'h00E0_0011);
        issue(32'h3409_0001);
        issue(32'h0000_4010);
        check("hilo_gap", 32'(o_stall), 0);

        // Unknown opcode and the all-zero NOP
        issue(32'hFC00_0000);
        check("unk_sel", 32'(o_sel), 0);
        check("unk_we",  32'(o_we), 0);
        issue(32'h0000_0000);
        check("nop_we",  32'(o_we), 0);

        // Reset asserted in the middle of a stall
        issue(32'h3401_0005);
        inst_valid = 1'b1; if_inst = 32'h0021_1025;
        @(negedge clk);
        check("pre_rst_stall", 32'(stall_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_alusel", 32'(alusel), 0);
        check("mrst_aluop",  32'(aluop), 0);
        check("mrst_reg2",   reg2_data, 0);
        check("mrst_we",     32'(id_we), 0);
        check("mrst_waddr",  32'(id_waddr), 0);
        check("mrst_stall",  32'(stall_req), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        ex_we = 1; ex_waddr = 5'd1; ex_wdata = 32'd5;
        run_cycle();
        check("post_rst_r1", o_r1, 5);
        clear_fwd();

        // Randomized stream; fetch holds the instruction while stalled
        for (int n = 0; n < 600; n++) begin
            if (!m_stall) begin
                inst_valid = ($urandom_range(0, 9) != 0);
                if_inst    = rand_inst();
            end
            ex_we  = 1'($urandom_range(0, 1)); ex_waddr  = 5'($urandom_range(0, 3)); ex_wdata  = rand_data();
            mem_we = 1'($urandom_range(0, 1)); mem_waddr = 5'($urandom_range(0, 3)); mem_wdata = rand_data();
            wb_we  = 1'($urandom_range(0, 1)); wb_waddr  = 5'($urandom_range(0, 3)); wb_wdata  = rand_data();
            rf_rdata1 = rand_data();
            rf_rdata2 = rand_data();
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
